// File: rtl/mux2_reg.sv
// Registered 2:1 multiplexer with select-change pulse reporting.
// Optional build macro MUX2_SWITCH_CNT_EN adds a 16-bit switch counter output sw_cnt.
module mux2_reg #(
  parameter int unsigned WIDTH     = 1,
  parameter logic [63:0] RESET_VAL = 64'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] out,
  output logic             sel_q,
`ifdef MUX2_SWITCH_CNT_EN
  output logic [15:0]      sw_cnt,
`endif
  output logic             sel_chg
);

  localparam logic [WIDTH-1:0] RST_OUT = RESET_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] mux_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             sel_q_q, sel_d;
  logic             chg_q, chg_d;

`ifdef MUX2_SWITCH_CNT_EN
  logic [15:0]      cnt_q, cnt_d;
`endif

  assign mux_d = s ? b : a;

  // NOTE: every signal written here gets its default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    out_d = out_q;
    sel_d = sel_q_q;
    chg_d = 1'b0;
`ifdef MUX2_SWITCH_CNT_EN
    cnt_d = cnt_q;
`endif
    if (en) begin
      out_d = mux_d;
      sel_d = s;
      chg_d = (s != sel_q_q);
`ifdef MUX2_SWITCH_CNT_EN
      if (s != sel_q_q) cnt_d = cnt_q + 16'd1;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= RST_OUT;
      sel_q_q <= 1'b0;
      chg_q   <= 1'b0;
`ifdef MUX2_SWITCH_CNT_EN
      cnt_q   <= 16'd0;
`endif
    end else begin
      out_q   <= out_d;
      sel_q_q <= sel_d;
      chg_q   <= chg_d;
`ifdef MUX2_SWITCH_CNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign out     = out_q;
  assign sel_q   = sel_q_q;
  assign sel_chg = chg_q;
`ifdef MUX2_SWITCH_CNT_EN
  assign sw_cnt  = cnt_q;
`endif

endmodule

// File: tb/tb_mux2_reg.sv
// Bench for mux2_reg: a 1-bit and an 8-bit instance share control inputs and are
// checked against a history-based reference model of accepted samples.
module tb_mux2_reg;

  localparam logic [7:0] W_RST = 8'h5A;  // wide instance RESET_VAL 'h15A truncated

  logic       clk = 1'b0;
  logic       rst, en, s;
  logic       n_a, n_b, n_out, n_sel, n_chg;
  logic [7:0] w_a, w_b, w_out;
  logic       w_sel, w_chg;
`ifdef MUX2_SWITCH_CNT_EN
  logic [15:0] n_cnt, w_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mux2_reg #(.WIDTH(1), .RESET_VAL(64'd0)) dut_n (
    .clk(clk), .rst(rst), .en(en), .a(n_a), .b(n_b), .s(s),
    .out(n_out), .sel_q(n_sel),
`ifdef MUX2_SWITCH_CNT_EN
    .sw_cnt(n_cnt),
`endif
    .sel_chg(n_chg));

  mux2_reg #(.WIDTH(8), .RESET_VAL(64'h15A)) dut_w (
    .clk(clk), .rst(rst), .en(en), .a(w_a), .b(w_b), .s(s),
    .out(w_out), .sel_q(w_sel),
`ifdef MUX2_SWITCH_CNT_EN
    .sw_cnt(w_cnt),
`endif
    .sel_chg(w_chg));

  // Reference model: a short history of accepted selects since the last reset.
  bit         sel_hist[$];
  logic       exp_n_out;
  logic [7:0] exp_w_out;
  logic       exp_chg;
  int         exp_cnt;

  function automatic logic exp_sel();
    return (sel_hist.size() == 0) ? 1'b0 : sel_hist[$];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      sel_hist.delete();
      exp_n_out = 1'b0;
      exp_w_out = W_RST;
      exp_chg   = 1'b0;
      exp_cnt   = 0;
    end else if (en) begin
      exp_chg   = (s != exp_sel());
      if (exp_chg) exp_cnt = (exp_cnt + 1) % 65536;
      sel_hist.push_back(s);
      if (sel_hist.size() > 4) void'(sel_hist.pop_front());
      exp_n_out = s ? n_b : n_a;
      exp_w_out = s ? w_b : w_a;
    end else begin
      exp_chg = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic e, input logic sv,
                       input logic na, input logic nb,
                       input logic [7:0] wa, input logic [7:0] wb);
    rst = r; en = e; s = sv; n_a = na; n_b = nb; w_a = wa; w_b = wb;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
      tick();
      n_tests++;
      if (n_out !== 1'b0 || w_out !== W_RST) begin
        n_fail++;
        $display("FAIL reset_out cyc%0d: got n=%b w=%h, want n=0 w=%h", c, n_out, w_out, W_RST);
      end
      n_tests++;
      if (n_sel !== 1'b0 || w_sel !== 1'b0 || n_chg !== 1'b0 || w_chg !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_sel cyc%0d: got sel=%b/%b chg=%b/%b, want 0", c, n_sel, w_sel, n_chg, w_chg);
      end
`ifdef MUX2_SWITCH_CNT_EN
      n_tests++;
      if (n_cnt !== 16'd0 || w_cnt !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_cnt cyc%0d: got %0d/%0d, want 0", c, n_cnt, w_cnt);
      end
`endif
    end
  endtask

  task automatic test_select_seq();
    logic [2:0] vec  [5] = '{3'b000, 3'b101, 3'b100, 3'b010, 3'b000}; // {a,b,s}
    logic       want [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       wchg [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] v;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    for (int i = 0; i < 5; i++) begin
      v = vec[i];
      drive(1'b0, 1'b1, v[0], v[2], v[1], 8'h00, 8'h00);
      tick();
      n_tests++;
      if (n_out !== want[i] || n_out !== exp_n_out) begin
        n_fail++;
        $display("FAIL seq_out[%0d]: got %b, want %b", i, n_out, want[i]);
      end
      n_tests++;
      if (n_chg !== wchg[i] || n_chg !== exp_chg || n_sel !== v[0]) begin
        n_fail++;
        $display("FAIL seq_chg[%0d]: got chg=%b sel=%b, want chg=%b sel=%b", i, n_chg, n_sel, wchg[i], v[0]);
      end
    end
`ifdef MUX2_SWITCH_CNT_EN
    n_tests++;
    if (n_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL seq_cnt: got %0d, want 2", n_cnt);
    end
`endif
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 8'h22);
    tick();
    n_tests++;
    if (n_out !== 1'b1 || w_out !== 8'h11) begin
      n_fail++;
      $display("FAIL hold_capture: got n=%b w=%h, want n=1 w=11", n_out, w_out);
    end
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b0, ~c[0], c[0], ~c[0], 8'(c * 37), 8'(c * 91 + 5));
      tick();
      n_tests++;
      if (n_out !== 1'b1 || w_out !== 8'h11 || n_sel !== 1'b0 || n_chg !== 1'b0 || w_chg !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d]: got out=%b/%h sel=%b chg=%b/%b, want 1/11 0 0/0",
                 c, n_out, w_out, n_sel, n_chg, w_chg);
      end
    end
  endtask

  task automatic test_wide();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C);
    tick();
    n_tests++;
    if (w_out !== 8'h3C) begin
      n_fail++;
      $display("FAIL wide_sel_b: got %h, want 3c", w_out);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C);
    tick();
    n_tests++;
    if (w_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL wide_sel_a: got %h, want a5", w_out);
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 8'($urandom));
      tick();
      n_tests++;
      if (w_out !== 8'hA5 || n_out !== 1'b0) begin
        n_fail++;
        $display("FAIL wide_unsel[%0d]: got %h/%b, want a5/0", c, w_out, n_out);
      end
    end
  endtask

  task automatic test_reset_priority();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 8'hEE);
    tick();
    n_tests++;
    if (w_out !== W_RST || n_out !== 1'b0 || w_sel !== 1'b0 || w_chg !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_prio: got out=%h sel=%b chg=%b, want %h 0 0", w_out, w_sel, w_chg, W_RST);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 8'hEE);
    tick();
    n_tests++;
    if (w_chg !== 1'b1 || n_chg !== 1'b1 || w_out !== 8'hEE || w_sel !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_prio_next: got chg=%b/%b out=%h sel=%b, want 1/1 ee 1", n_chg, w_chg, w_out, w_sel);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7), 1'($urandom),
            1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      tick();
      n_tests++;
      if (n_out !== exp_n_out || w_out !== exp_w_out || n_sel !== exp_sel() || w_sel !== exp_sel()
          || n_chg !== exp_chg || w_chg !== exp_chg) begin
        n_fail++;
        $display("FAIL rand[%0d]: got out=%b/%h sel=%b/%b chg=%b/%b, want %b/%h %b %b",
                 c, n_out, w_out, n_sel, w_sel, n_chg, w_chg, exp_n_out, exp_w_out, exp_sel(), exp_chg);
      end
`ifdef MUX2_SWITCH_CNT_EN
      n_tests++;
      if (n_cnt !== 16'(exp_cnt) || w_cnt !== 16'(exp_cnt)) begin
        n_fail++;
        $display("FAIL rand_cnt[%0d]: got %0d/%0d, want %0d", c, n_cnt, w_cnt, exp_cnt);
      end
`endif
    end
  endtask

`ifdef MUX2_SWITCH_CNT_EN
  task automatic test_cnt_wrap();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    for (int c = 0; c < 65535; c++) begin
      drive(1'b0, 1'b1, ~c[0], 1'b0, 1'b1, 8'h00, 8'h01);
      tick();
    end
    n_tests++;
    if (n_cnt !== 16'hFFFF || w_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL cnt_max: got %h/%h, want ffff", n_cnt, w_cnt);
    end
    drive(1'b0, 1'b1, ~s, 1'b0, 1'b1, 8'h00, 8'h01);
    tick();
    n_tests++;
    if (n_cnt !== 16'h0000 || w_cnt !== 16'h0000 || exp_cnt != 0) begin
      n_fail++;
      $display("FAIL cnt_wrap: got %h/%h, want 0000", n_cnt, w_cnt);
    end
  endtask
`endif

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    test_reset();
    test_select_seq();
    test_hold();
    test_wide();
    test_reset_priority();
    test_random();
`ifdef MUX2_SWITCH_CNT_EN
    test_cnt_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux2_reg.md
Name: mux2_reg

Overview:
- Registered 2:1 multiplexer for datapath steering.
- One of two equal-width data inputs is selected by a 1-bit select. The result is captured into an output register on the rising clock edge.
- A status flag reports when the select value has changed between accepted samples.
- Sits between producer logic and any consumer that needs a glitch-free, clock-aligned selected value.

Parameters:
- WIDTH, 1, bit width of data inputs a, b and output out (legal range 1..64).
- RESET_VAL, 0, value loaded into out on reset (WIDTH bits, zero-extended or truncated to WIDTH).

Ports:
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable; 1 = sample the selected input this cycle.
- a  input  WIDTH  data input 0, selected when s = 0.
- b  input  WIDTH  data input 1, selected when s = 1.
- s  input  1  select.
- out  output  WIDTH  registered selected data.
- sel_q  output  1  select value of the last accepted sample.
- sel_chg  output  1  one-cycle pulse; the last accepted sample's select differed from the previous accepted select.

Behaviour:
- Reset: one clock: reset is synchronous and active-high. If rst = 1 at a rising clk edge:
  - out <= RESET_VAL, sel_q <= 0, sel_chg <= 0.
  - rst has priority over en.
  - Reset asserted mid-stream discards that cycle's sample.
- Select function: mux_d = s ? b : a. Bitwise, no arithmetic, no width change.
- Capture, when rst = 0 and en = 1 at the edge:
  - out <= mux_d, sel_q <= s.
  - sel_chg <= (s != sel_q).
- Hold, when rst = 0 and en = 0:
  - out and sel_q hold.
  - sel_chg <= 0.
- Latency: exactly 1 clock from the sampled (a, b, s, en) to out. No combinational path from inputs to any output.
- X/Z on s while en = 1: no defined result required. The bench must drive s to a known value.
- Changes on the unselected input never affect out.
- sel_chg is never asserted in the cycle after reset.
- The first accepted sample after reset compares against sel_q = 0.

Optional Feature:
- Macro: MUX2_SWITCH_CNT_EN.
- When defined, adds output port sw_cnt (16 bits):
  - Counts accepted samples whose select differed from sel_q, i.e. increments exactly when sel_chg is being set to 1.
  - Cleared to 0 by rst.
  - Wraps from 0xFFFF to 0x0000; no saturation.
- When undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: rst = 1 for 2 cycles with a = 1, b = 1, s = 1, en = 1 -> out = RESET_VAL (0), sel_q = 0, sel_chg = 0 after each edge.
- Select sequence, WIDTH = 1, en = 1, one vector per clock -> out follows one cycle later:
  - (a, b, s) = (0,0,0) -> 0
  - (1,0,1) -> 0
  - (1,0,0) -> 1
  - (0,1,0) -> 0
  - (0,0,0) -> 0
- Select-change pulse, same sequence:
  - sel_chg = 0,1,1,0,0 after the respective edges.
  - With MUX2_SWITCH_CNT_EN, sw_cnt = 2 at the end.
- Hold: capture a = 1, s = 0 (out = 1), then en = 0 while toggling a, b, s for 5 cycles -> out stays 1, sel_q stays 0, sel_chg = 0.
- Wide data, WIDTH = 8:
  - a = 0xA5, b = 0x3C, s = 1 -> out = 0x3C.
  - Then s = 0 -> out = 0xA5.
  - Then changing b only -> out unchanged.
- Reset priority: rst = 1 and en = 1 in the same cycle with s = 1 -> out = RESET_VAL, sel_q = 0, sel_chg = 0.
  - Next capture with s = 1 -> sel_chg = 1.
